// File: rtl/sign_pkg.sv
// Shared definitions for the signature stream packer.
//   state_e   : packer FSM states
//   DEF_*     : default field widths
//   sig_words : total stream length in OUT_W words
//   next_set  : lowest set bit at or above a pointer (MASK_MAX = none)
package sign_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_HDR,
    ST_SEED,
    ST_CV,
    ST_Z,
    ST_TAIL,
    ST_FIN
  } state_e;

  localparam int unsigned DEF_N_INST = 8;
  localparam int unsigned DEF_N_OPEN = 4;
  localparam int unsigned DEF_HDR_W  = 512;
  localparam int unsigned DEF_SEED_W = 128;
  localparam int unsigned DEF_CV_W   = 256;
  localparam int unsigned DEF_Z_W    = 4864;
  localparam int unsigned DEF_TAIL_W = 128;
  localparam int unsigned DEF_OUT_W  = 64;

  // Widest instance mask the priority search handles.
  localparam int unsigned MASK_MAX = 64;
  localparam int unsigned MASK_IW  = 6;

  function automatic int unsigned sig_words(input int unsigned n_inst,
                                            input int unsigned n_open,
                                            input int unsigned hdr_w,
                                            input int unsigned seed_w,
                                            input int unsigned cv_w,
                                            input int unsigned z_w,
                                            input int unsigned tail_w,
                                            input int unsigned out_w);
    return (hdr_w + (n_inst - n_open) * (seed_w + cv_w) + n_open * z_w + tail_w) / out_w;
  endfunction

  function automatic int unsigned next_set(input logic [MASK_MAX-1:0] mask,
                                           input int unsigned ptr);
    int unsigned r;
    r = MASK_MAX;
    for (int unsigned i = 0; i < MASK_MAX; i++) begin
      if (r == MASK_MAX && i >= ptr && mask[MASK_IW'(i)]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/open_mask_decoder.sv
// Challenge-list decoder.
//   lc   : N_OPEN indices of IDX_W bits, entry 0 in the MS slice
//   mask : one bit per instance set when that instance is challenged
//   err  : an index is out of range or an index repeats
module open_mask_decoder #(
  parameter int unsigned N_INST = 8,
  parameter int unsigned N_OPEN = 4,
  parameter int unsigned IDX_W  = $clog2(N_INST)
) (
  input  logic [N_OPEN*IDX_W-1:0] lc,
  output logic [N_INST-1:0]       mask,
  output logic                    err
);

  logic [IDX_W-1:0]  idx [N_OPEN];
  logic [N_OPEN-1:0] oob;

  for (genvar gk = 0; gk < N_OPEN; gk++) begin : g_idx
    assign idx[gk] = lc[(N_OPEN-1-gk)*IDX_W +: IDX_W];
    assign oob[gk] = 32'(idx[gk]) >= N_INST;
  end

  for (genvar gi = 0; gi < N_INST; gi++) begin : g_bit
    logic [N_OPEN-1:0] eq;
    for (genvar gk = 0; gk < N_OPEN; gk++) begin : g_eq
      assign eq[gk] = 32'(idx[gk]) == gi;
    end
    assign mask[gi] = |eq;
  end

  // A duplicate collapses two entries onto one mask bit, so the count falls short.
  assign err = (|oob) || ($countones(mask) != N_OPEN);

endmodule

// File: rtl/sign_stream_packer.sv
// Signature serialiser: validates the challenge list, then streams
// header, unopened seeds, unopened commitments, opened Z records and the
// tail as OUT_W-bit valid/ready words, MS word first in every field.
//   start/lc            : request and challenged indices
//   hdr_i .. tail_i     : signature fields (instance 0 in the MS slice)
//   out_data/valid/last : output stream, out_ready back-pressure
//   busy/done/err       : status; err accompanies done on a bad list
module sign_stream_packer
  import sign_pkg::*;
#(
  parameter int unsigned N_INST = DEF_N_INST,
  parameter int unsigned N_OPEN = DEF_N_OPEN,
  parameter int unsigned IDX_W  = $clog2(N_INST),
  parameter int unsigned HDR_W  = DEF_HDR_W,
  parameter int unsigned SEED_W = DEF_SEED_W,
  parameter int unsigned CV_W   = DEF_CV_W,
  parameter int unsigned Z_W    = DEF_Z_W,
  parameter int unsigned TAIL_W = DEF_TAIL_W,
  parameter int unsigned OUT_W  = DEF_OUT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [N_OPEN*IDX_W-1:0]  lc,
  input  logic [HDR_W-1:0]         hdr_i,
  input  logic [N_INST*SEED_W-1:0] seed_star_i,
  input  logic [N_INST*CV_W-1:0]   cv_i,
  input  logic [N_INST*Z_W-1:0]    z_i,
  input  logic [TAIL_W-1:0]        tail_i,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned HDR_WORDS  = HDR_W / OUT_W;
  localparam int unsigned SEED_WORDS = SEED_W / OUT_W;
  localparam int unsigned CV_WORDS   = CV_W / OUT_W;
  localparam int unsigned Z_WORDS    = Z_W / OUT_W;
  localparam int unsigned TAIL_WORDS = TAIL_W / OUT_W;
  localparam int unsigned CNT_W      = 16;

  localparam int unsigned HDR_AW  = $clog2(HDR_W);
  localparam int unsigned SEED_AW = $clog2(N_INST * SEED_W);
  localparam int unsigned CV_AW   = $clog2(N_INST * CV_W);
  localparam int unsigned Z_AW    = $clog2(N_INST * Z_W);
  localparam int unsigned TAIL_AW = $clog2(TAIL_W);

  if ((HDR_W % OUT_W) != 0 || (SEED_W % OUT_W) != 0 || (CV_W % OUT_W) != 0 ||
      (Z_W % OUT_W) != 0 || (TAIL_W % OUT_W) != 0) begin : g_bad_width
    $error("sign_stream_packer: field widths must be multiples of OUT_W");
  end
  if (N_OPEN >= N_INST || N_INST > MASK_MAX || Z_WORDS >= (1 << CNT_W)) begin : g_bad_count
    $error("sign_stream_packer: unsupported N_INST/N_OPEN/field size");
  end

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         word_q, word_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic [N_OPEN*IDX_W-1:0]  lc_q, lc_d;
  logic [N_INST-1:0]        mask_q, mask_d;
  logic                     err_q, err_d;

  logic [N_INST-1:0]        dec_mask;
  logic                     dec_err;
  logic [N_INST-1:0]        inv_mask;
  logic [31:0]              first_open, first_closed, next_open, next_closed;
  logic [CNT_W-1:0]         field_words;
  logic                     field_end;
  logic                     hs;
  logic [31:0]              w, p;

  open_mask_decoder #(
    .N_INST (N_INST),
    .N_OPEN (N_OPEN),
    .IDX_W  (IDX_W)
  ) u_dec (
    .lc   (lc_q),
    .mask (dec_mask),
    .err  (dec_err)
  );

  // Priority search over the opened mask and its inverse; the inverse is
  // formed at N_INST bits so the zero-extension leaves no phantom instances.
  always_comb begin
    inv_mask     = ~mask_q;
    first_open   = next_set(64'(mask_q), 0);
    first_closed = next_set(64'(inv_mask), 0);
    next_open    = next_set(64'(mask_q), 32'(ptr_q) + 32'd1);
    next_closed  = next_set(64'(inv_mask), 32'(ptr_q) + 32'd1);
  end

  always_comb begin
    field_words = CNT_W'(1);
    case (state_q)
      ST_HDR:  field_words = CNT_W'(HDR_WORDS);
      ST_SEED: field_words = CNT_W'(SEED_WORDS);
      ST_CV:   field_words = CNT_W'(CV_WORDS);
      ST_Z:    field_words = CNT_W'(Z_WORDS);
      ST_TAIL: field_words = CNT_W'(TAIL_WORDS);
      default: field_words = CNT_W'(1);
    endcase
    field_end = (word_q == field_words - CNT_W'(1));
  end

  always_comb begin
    out_valid = state_q inside {ST_HDR, ST_SEED, ST_CV, ST_Z, ST_TAIL};
    out_last  = (state_q == ST_TAIL) && field_end;
    busy      = state_q inside {ST_CHECK, ST_HDR, ST_SEED, ST_CV, ST_Z, ST_TAIL};
    done      = (state_q == ST_FIN);
    err       = err_q;
    hs        = out_valid & out_ready;
  end

  // Words are read straight out of the held inputs; nothing is buffered.
  always_comb begin
    w        = 32'(word_q);
    p        = 32'(ptr_q);
    out_data = '0;
    case (state_q)
      ST_HDR:  out_data = hdr_i[HDR_AW'((HDR_WORDS-1-w)*OUT_W) +: OUT_W];
      ST_SEED: out_data = seed_star_i[SEED_AW'((N_INST-1-p)*SEED_W + (SEED_WORDS-1-w)*OUT_W) +: OUT_W];
      ST_CV:   out_data = cv_i[CV_AW'((N_INST-1-p)*CV_W + (CV_WORDS-1-w)*OUT_W) +: OUT_W];
      ST_Z:    out_data = z_i[Z_AW'((N_INST-1-p)*Z_W + (Z_WORDS-1-w)*OUT_W) +: OUT_W];
      ST_TAIL: out_data = tail_i[TAIL_AW'((TAIL_WORDS-1-w)*OUT_W) +: OUT_W];
      default: out_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    ptr_d   = ptr_q;
    lc_d    = lc_q;
    mask_d  = mask_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          lc_d    = lc;
          err_d   = 1'b0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        mask_d = dec_mask;
        word_d = '0;
        ptr_d  = '0;
        if (dec_err) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (hs) begin
          if (field_end) begin
            word_d  = '0;
            ptr_d   = IDX_W'(first_closed);
            state_d = ST_SEED;
          end else begin
            word_d = word_q + CNT_W'(1);
          end
        end
      end
      ST_SEED: begin
        if (hs) begin
          if (!field_end) begin
            word_d = word_q + CNT_W'(1);
          end else begin
            word_d = '0;
            if (next_closed < N_INST) begin
              ptr_d = IDX_W'(next_closed);
            end else begin
              ptr_d   = IDX_W'(first_closed);
              state_d = ST_CV;
            end
          end
        end
      end
      ST_CV: begin
        if (hs) begin
          if (!field_end) begin
            word_d = word_q + CNT_W'(1);
          end else begin
            word_d = '0;
            if (next_closed < N_INST) begin
              ptr_d = IDX_W'(next_closed);
            end else if (first_open < N_INST) begin
              ptr_d   = IDX_W'(first_open);
              state_d = ST_Z;
            end else begin
              ptr_d   = '0;
              state_d = ST_TAIL;
            end
          end
        end
      end
      ST_Z: begin
        if (hs) begin
          if (!field_end) begin
            word_d = word_q + CNT_W'(1);
          end else begin
            word_d = '0;
            if (next_open < N_INST) begin
              ptr_d = IDX_W'(next_open);
            end else begin
              ptr_d   = '0;
              state_d = ST_TAIL;
            end
          end
        end
      end
      ST_TAIL: begin
        if (hs) begin
          if (!field_end) begin
            word_d = word_q + CNT_W'(1);
          end else begin
            word_d  = '0;
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      ptr_q   <= '0;
      lc_q    <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      ptr_q   <= ptr_d;
      lc_q    <= lc_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_sign_stream_packer.sv
// Self-checking bench for sign_stream_packer: an 8-instance and a
// 16-instance packer share one stimulus/scoreboard path selected per case.
module tb_sign_stream_packer;
  import sign_pkg::*;

  localparam int unsigned N8  = 8;
  localparam int unsigned N16 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        start8 = 1'b0, start16 = 1'b0;
  logic        out_ready = 1'b1;
  logic [11:0] lc8 = '0;
  logic [15:0] lc16 = '0;
  logic [511:0] hdr = '0;
  logic [127:0] tail = '0;
  logic [N8*128-1:0]   seed8 = '0;
  logic [N8*256-1:0]   cv8 = '0;
  logic [N8*4864-1:0]  z8 = '0;
  logic [N16*128-1:0]  seed16 = '0;
  logic [N16*256-1:0]  cv16 = '0;
  logic [N16*4864-1:0] z16 = '0;

  logic [63:0] d8, d16;
  logic v8, l8, b8, dn8, e8, v16, l16, b16, dn16, e16;

  sign_stream_packer dut8 (
    .clk(clk), .reset(reset), .start(start8), .lc(lc8), .hdr_i(hdr),
    .seed_star_i(seed8), .cv_i(cv8), .z_i(z8), .tail_i(tail),
    .out_data(d8), .out_valid(v8), .out_ready(out_ready), .out_last(l8),
    .busy(b8), .done(dn8), .err(e8)
  );

  sign_stream_packer #(.N_INST(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .lc(lc16), .hdr_i(hdr),
    .seed_star_i(seed16), .cv_i(cv16), .z_i(z16), .tail_i(tail),
    .out_data(d16), .out_valid(v16), .out_ready(out_ready), .out_last(l16),
    .busy(b16), .done(dn16), .err(e16)
  );

  logic sel = 1'b0;
  logic [63:0] cur_data;
  logic cur_valid, cur_last, cur_busy, cur_done, cur_err;
  assign cur_data  = sel ? d16  : d8;
  assign cur_valid = sel ? v16  : v8;
  assign cur_last  = sel ? l16  : l8;
  assign cur_busy  = sel ? b16  : b8;
  assign cur_done  = sel ? dn16 : dn8;
  assign cur_err   = sel ? e16  : e8;

  int errors = 0;
  int checks = 0;
  logic [31:0] salt;

  typedef struct packed { logic last; logic [63:0] data; } exp_t;
  exp_t exp_q[$];
  logic [63:0] got[$];

  typedef struct {
    bit big;
    int l0, l1, l2, l3;
    bit rnd;
    int rst_at;
    bit st_busy;
    bit exp_err;
    int exp_words;
  } tcase_t;
  tcase_t tcs[$];

  // Word tag: field, instance, word-in-field, per-run salt.
  function automatic logic [63:0] wv(input int f, input int i, input int k);
    return {8'(f), 8'(i), 16'(k), salt};
  endfunction

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic chki(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic add_case(input bit big, input int l0, input int l1, input int l2, input int l3,
                          input bit rnd, input int rst_at, input bit st_busy,
                          input bit exp_err, input int exp_words);
    tcase_t t;
    t.big = big; t.l0 = l0; t.l1 = l1; t.l2 = l2; t.l3 = l3;
    t.rnd = rnd; t.rst_at = rst_at; t.st_busy = st_busy;
    t.exp_err = exp_err; t.exp_words = exp_words;
    tcs.push_back(t);
  endtask

  task automatic push(input logic [63:0] d, input logic last);
    exp_t e;
    e.data = d;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic build_exp(input tcase_t t);
    int n;
    logic [15:0] opm;
    n = t.big ? 16 : 8;
    opm = (16'd1 << t.l0) | (16'd1 << t.l1) | (16'd1 << t.l2) | (16'd1 << t.l3);
    for (int k = 0; k < 8; k++) push(wv(1, 0, k), 1'b0);
    for (int i = 0; i < n; i++)
      if (((opm >> i) & 16'd1) == 16'd0)
        for (int k = 0; k < 2; k++) push(wv(2, i, k), 1'b0);
    for (int i = 0; i < n; i++)
      if (((opm >> i) & 16'd1) == 16'd0)
        for (int k = 0; k < 4; k++) push(wv(3, i, k), 1'b0);
    for (int i = 0; i < n; i++)
      if (((opm >> i) & 16'd1) != 16'd0)
        for (int k = 0; k < 76; k++) push(wv(4, i, k), 1'b0);
    push(wv(5, 0, 0), 1'b0);
    push(wv(5, 0, 1), 1'b1);
  endtask

  task automatic set_start(input bit big, input logic v);
    if (big) start16 = v; else start8 = v;
  endtask

  task automatic run_case(input tcase_t t);
    int c, nw, last_hs, done_c;
    bit stall;
    logic [63:0] held_d;
    logic held_l;
    exp_t e;
    sel = t.big;
    lc8  = {3'(t.l0), 3'(t.l1), 3'(t.l2), 3'(t.l3)};
    lc16 = {4'(t.l0), 4'(t.l1), 4'(t.l2), 4'(t.l3)};
    exp_q.delete();
    got.delete();
    if (!t.exp_err) build_exp(t);
    @(negedge clk);
    set_start(t.big, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    set_start(t.big, 1'b0);
    c = 1;
    chk1("busy_cycle1", cur_busy, 1'b1);
    chk1("err_cleared_cycle1", cur_err, 1'b0);
    chk1("valid_cycle1", cur_valid, 1'b0);
    nw = 0; stall = 0; done_c = -1; last_hs = -1;
    held_d = '0; held_l = 1'b0;
    while (c < 3000) begin
      if (stall) begin
        chk1("stall_valid_held", cur_valid, 1'b1);
        chk64("stall_data_held", cur_data, held_d);
        chk1("stall_last_held", cur_last, held_l);
      end
      if (cur_done) begin
        done_c = c;
        break;
      end
      if (t.rst_at >= 0 && nw == t.rst_at) begin
        reset = 1'b1;
        #1;
        chk1("reset_valid_drop", cur_valid, 1'b0);
        chk1("reset_busy_drop", cur_busy, 1'b0);
        chk64("reset_data_zero", cur_data, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < 6; j++) begin
          @(negedge clk);
          chk1("no_done_after_reset", cur_done, 1'b0);
        end
        chki("words_before_reset", nw, t.exp_words);
        exp_q.delete();
        return;
      end
      set_start(t.big, (t.st_busy && c == 40) ? 1'b1 : 1'b0);
      out_ready = t.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stall = 0;
      if (cur_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word actual=%h required=none", cur_data);
          end else begin
            e = exp_q.pop_front();
            chk64("word_data", cur_data, e.data);
            chk1("word_last", cur_last, e.last);
          end
          got.push_back(cur_data);
          nw++;
          last_hs = c;
        end else begin
          stall = 1;
          held_d = cur_data;
          held_l = cur_last;
        end
      end
      @(negedge clk);
      c++;
    end
    set_start(t.big, 1'b0);
    if (done_c < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=none required=done");
    end
    chk1("err_at_done", cur_err, t.exp_err);
    chk1("valid_at_done", cur_valid, 1'b0);
    chki("word_count", nw, t.exp_words);
    chki("scoreboard_left", exp_q.size(), 0);
    if (t.exp_err) chki("done_cycle_err", done_c, 2);
    else chki("done_after_last_hs", done_c, last_hs + 1);
    if (!t.exp_err && !t.rnd) chki("done_cycle_full_rate", done_c, t.exp_words + 2);
    // A start during the done cycle must be ignored.
    set_start(t.big, 1'b1);
    @(negedge clk);
    set_start(t.big, 1'b0);
    chk1("done_is_pulse", cur_done, 1'b0);
    chk1("idle_after_done", cur_busy, 1'b0);
    @(negedge clk);
    chk1("start_in_done_ignored", cur_busy, 1'b0);
    chk1("err_held", cur_err, t.exp_err);
  endtask

  initial begin
    salt = $urandom();
    for (int k = 0; k < 8; k++) hdr = {hdr[447:0], wv(1, 0, k)};
    for (int k = 0; k < 2; k++) tail = {tail[63:0], wv(5, 0, k)};
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 2; k++) seed8 = {seed8[N8*128-65:0], wv(2, i, k)};
      for (int k = 0; k < 4; k++) cv8 = {cv8[N8*256-65:0], wv(3, i, k)};
      for (int k = 0; k < 76; k++) z8 = {z8[N8*4864-65:0], wv(4, i, k)};
    end
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 2; k++) seed16 = {seed16[N16*128-65:0], wv(2, i, k)};
      for (int k = 0; k < 4; k++) cv16 = {cv16[N16*256-65:0], wv(3, i, k)};
      for (int k = 0; k < 76; k++) z16 = {z16[N16*4864-65:0], wv(4, i, k)};
    end

    //        big l0 l1 l2 l3  rnd rst  stb err words
    add_case(0, 1, 3, 4, 6,   0, -1,  0,  0, 338);
    add_case(0, 1, 3, 4, 6,   1, -1,  1,  0, 338);
    add_case(0, 2, 2, 5, 7,   0, -1,  0,  1, 0);
    add_case(1, 0, 15, 8, 9,  0, -1,  0,  0, 386);
    add_case(0, 1, 3, 4, 6,   0, 100, 0,  0, 100);
    add_case(0, 1, 3, 4, 6,   0, -1,  0,  0, 338);
    add_case(0, 7, 0, 3, 2,   1, -1,  0,  0, 338);

    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk64("reset_out_data", d8, 64'd0);
    chk1("reset_out_valid", v8, 1'b0);
    chk1("reset_out_last", l8, 1'b0);
    chk1("reset_busy", b8, 1'b0);
    chk1("reset_done", dn8, 1'b0);
    chk1("reset_err", e8, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    for (int ci = 0; ci < tcs.size(); ci++) begin
      run_case(tcs[ci]);
      if (ci == 0 && got.size() == 338) begin
        chk64("w8_seed0_w0", got[8], wv(2, 0, 0));
        chk64("w9_seed0_w1", got[9], wv(2, 0, 1));
        chk64("w10_seed2_w0", got[10], wv(2, 2, 0));
        chk64("w14_seed7_w0", got[14], wv(2, 7, 0));
        chk64("w32_z1_w0", got[32], wv(4, 1, 0));
        chk64("w337_tail_w1", got[337], wv(5, 0, 1));
      end
      if (ci == 3 && got.size() == 386) begin
        chk64("big_z0_first", got[80], wv(4, 0, 0));
        chk64("big_z8_second", got[156], wv(4, 8, 0));
        chk64("big_z9_third", got[232], wv(4, 9, 0));
        chk64("big_z15_fourth", got[308], wv(4, 15, 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
